s_divider: RTL and testbench
============================

// Module: s_divider
// PURPOSE
//  Sequential restoring (shift-subtract) unsigned divider; the inverse of the shift-add S_Multi multiplier.
//  Divides a DW-bit dividend by a VW-bit divisor, producing one quotient bit per clock.
//  Sits beside the multiplier in the lab datapath; start/busy/done handshake to the controlling FSM.
// PARAMETERS
//  DW  8  dividend and quotient width (bits); also the iteration count
//  VW  4  divisor and remainder width (bits)
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  reset       in   1   synchronous, active-high reset
//  start       in   1   request; sampled only in IDLE
//  dividend    in   DW  numerator, captured on the accepted start edge
//  divisor     in   VW  denominator, captured on the accepted start edge
//  quotient    out  DW  result, registered, held until the next completion
//  remainder   out  VW  result, registered, held until the next completion
//  busy        out  1   high while a division is in progress
//  done        out  1   one-cycle pulse; results valid from this cycle
//  div_by_zero out  1   high with done when the captured divisor was 0; held with the results
// BEHAVIOUR
//  Reset: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, FSM->IDLE, counter=0. Reset wins over start.
//  FSM states: IDLE, RUN.
//   IDLE: start=1 at edge E0 -> latch dividend into shift reg, divisor into d reg, clear partial rem (VW+1 bits),
//         cnt<=DW-1, busy<=1, state<=RUN. done is always 0 in IDLE except its one-cycle pulse.
//   RUN, each edge: r' = {r[VW-1:0], q_msb}; shift q left; if r' >= d then r<=r'-d, q_lsb<=1, else r<=r', q_lsb<=0.
//         Subtraction uses the VW+1-bit partial rem; no overflow possible.
//         On the edge with cnt==0: load quotient/remainder outputs, done<=1, busy<=0, state<=IDLE.
//  Latency: done and results visible after edge E0+DW (8 clocks at defaults); busy high for exactly DW cycles.
//  Back-to-back: start high during the done cycle is accepted (FSM is IDLE); next done at +DW edges.
//  start while busy: ignored, no effect on the running division or on held outputs.
//  Outputs quotient/remainder/div_by_zero change only on completion edges (or reset); not cleared by start.
//  Divisor 0: quotient=all ones, remainder=0, div_by_zero=1 at completion; latency as in CONFIGURATION.
//  dividend < divisor: quotient=0, remainder=dividend (fits VW bits by definition).
//  Reset mid-RUN: abort; next cycle all outputs at reset values, IDLE; no done pulse is ever generated.
//  Inputs dividend/divisor may change freely after the capture edge without affecting the result.
// CONFIGURATION
//  S_DIVIDER_DBZ_FAST_EN defined: zero divisor detected at capture; FSM skips RUN and completes on
//    edge E0+1 (busy high 1 cycle) with quotient=all ones, remainder=0, div_by_zero=1.
//  Not defined: zero divisor runs the full DW iterations; the final result is forced to
//    all ones / 0 / div_by_zero=1; latency is identical to a normal division (constant-time).
// TESTING
//  1. reset 1 cycle, then dividend=100, divisor=7, start 1 cycle -> busy 8 cycles, done pulse, quotient=14, remainder=2.
//  2. 255/1 -> quotient=255, remainder=0; then 6/15 -> quotient=0, remainder=6; div_by_zero=0 in both.
//  3. 0x55/0 -> quotient=0xFF, remainder=0, div_by_zero=1; done after 8 edges (1 edge with S_DIVIDER_DBZ_FAST_EN).
//  4. 200/9 started, start pulsed again with 50/5 at cycle 3 of RUN -> ignored; result 22 rem 2 only.
//  5. start 13/4 in the done cycle of a prior 100/7 -> first 14 r2, then 3 r1 exactly 8 edges later.
//  6. reset asserted at RUN cycle 4 of 100/7 -> outputs 0, busy 0, no done; subsequent 9/2 gives 4 r1.

Source files
------------

// File: rtl/s_divider.sv
`default_nettype none
// ============================================================================
// Module      : s_divider
// Description : Sequential restoring (shift-subtract) unsigned divider that
//               produces one quotient bit per clock, with a start/busy/done
//               handshake. Optional macro S_DIVIDER_DBZ_FAST_EN makes a zero
//               divisor complete one edge after capture instead of running
//               all DW iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module s_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int            CW         = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] c_CNT_INIT = CW'(DW - 1);

`ifdef S_DIVIDER_DBZ_FAST_EN
    localparam bit c_DBZ_FAST = 1'b1;
`else
    localparam bit c_DBZ_FAST = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_load;
    logic          w_step;
    logic          w_finish;

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [VW-1:0] r_rem;
    logic          r_dbz;

    logic [VW:0]   w_rshift;
    logic          w_ge;
    logic [VW-1:0] w_rnext;
    logic [DW-1:0] w_qnext;
    logic          w_dzero;
    logic [CW-1:0] w_cnt_load;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-subtract step
    // ------------------------------------------------------------------
    // The stored partial remainder is always below the divisor, so it fits
    // VW bits; only the shifted value needs the extra bit for the compare.
    // The VW-bit subtraction is exact because the true difference is < d.
    always_comb begin
        w_rshift = {r_rem, r_q[DW-1]};
        w_ge     = (w_rshift >= {1'b0, r_d});
        w_rnext  = w_ge ? (w_rshift[VW-1:0] - r_d) : w_rshift[VW-1:0];
        w_qnext  = (r_q << 1) | DW'(w_ge);
    end

    // A fast zero-divisor completion just starts the counter at its last value.
    assign w_dzero    = (divisor == '0);
    assign w_cnt_load = (c_DBZ_FAST && w_dzero) ? '0 : c_CNT_INIT;

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;

            if (w_load) begin
                r_q   <= dividend;
                r_d   <= divisor;
                r_rem <= '0;
                r_dbz <= w_dzero;
                r_cnt <= w_cnt_load;
                busy  <= 1'b1;
            end

            if (w_step) begin
                r_q   <= w_qnext;
                r_rem <= w_rnext;
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_finish) begin
                quotient    <= r_dbz ? '1 : w_qnext;
                remainder   <= r_dbz ? '0 : w_rnext;
                div_by_zero <= r_dbz;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_s_divider
// Description : Scoreboard bench for s_divider: directed cases plus random
//               divisions checked against plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s_divider;

    localparam int DW = 8;
    localparam int VW = 4;

`ifdef S_DIVIDER_DBZ_FAST_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    s_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        int            at;
        int            lat;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] last_q   = '0;
    logic [VW-1:0] last_r   = '0;
    logic          last_dbz = 1'b0;
    int            blen     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse; between completions the
    // outputs must hold the last completed result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_q   = '0;
                last_r   = '0;
                last_dbz = 1'b0;
                blen     = 0;
            end else begin
                if (busy) blen++;
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done=1 expected no pending division (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", 32'(quotient), 32'(e.q));
                        check("remainder", 32'(remainder), 32'(e.r));
                        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                        check("done_cycle", cyc, e.at);
                        check("busy_cycles", blen, e.lat);
                        last_q   = e.q;
                        last_r   = e.r;
                        last_dbz = e.dbz;
                    end
                    check("busy_in_done", 32'(busy), 32'(0));
                    blen = 0;
                end else begin
                    check("held_quotient", 32'(quotient), 32'(last_q));
                    check("held_remainder", 32'(remainder), 32'(last_r));
                    check("held_dbz", 32'(div_by_zero), 32'(last_dbz));
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        sb.delete();
        @(posedge clk); #2;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        reset = 1'b0;
    endtask

    // Issues one start pulse (DUT must be idle) and records the expected result.
    task automatic issue(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        exp_t e;
        int   a;
        int   b;
        a     = int'(dd);
        b     = int'(dv);
        e.dbz = (b == 0);
        e.q   = e.dbz ? {DW{1'b1}} : DW'(a / b);
        e.r   = e.dbz ? '0 : VW'(a % b);
        e.lat = (c_FAST && e.dbz) ? 1 : DW;
        e.at  = cyc + 1 + e.lat;
        sb.push_back(e);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #2;
        start    = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < DW + 4; i++) begin
            if (done) return;
            @(posedge clk); #2;
        end
        checks++;
        failures++;
        $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse (cycle %0d)", DW + 4, cyc);
    endtask

    task automatic pulse_start_busy(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #2;
        start    = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rdd;
        logic [VW-1:0] rdv;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        do_reset();

        issue(8'd100, 4'd7);  wait_done();
        @(posedge clk); #2;
        issue(8'd255, 4'd1);  wait_done();
        issue(8'd6, 4'd15);   wait_done();
        @(posedge clk); #2;
        issue(8'h55, 4'd0);   wait_done();
        @(posedge clk); #2;

        // start while busy must be ignored
        issue(8'd200, 4'd9);
        repeat (2) begin @(posedge clk); #2; end
        pulse_start_busy(8'd50, 4'd5);
        wait_done();
        @(posedge clk); #2;

        // back-to-back: second start in the done cycle of the first
        issue(8'd100, 4'd7);  wait_done();
        issue(8'd13, 4'd4);   wait_done();
        @(posedge clk); #2;

        // abort mid-run, then a clean division
        issue(8'd100, 4'd7);
        repeat (3) begin @(posedge clk); #2; end
        do_reset();
        issue(8'd9, 4'd2);    wait_done();
        @(posedge clk); #2;

        for (int k = 0; k < 40; k++) begin
            rdd = DW'($urandom);
            rdv = ($urandom_range(0, 6) == 0) ? '0 : VW'($urandom);
            issue(rdd, rdv);
            if (busy && ($urandom_range(0, 2) == 0))
                pulse_start_busy(DW'($urandom), VW'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
        end

        for (int i = 0; i < 3 * DW && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected $finish before 200000 time units");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
